// File: rtl/arb2_mux_ctrl_pkg.sv
// arb2_mux_ctrl_pkg: state encoding and reset constants shared by the arbiter RTL and its bench.
package arb2_mux_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;
  localparam logic LAST_RST = 1'b1;
endpackage

// File: rtl/arb2_mux_ctrl_mux.sv
// mux2x1_data: WIDTH-wide 2:1 datapath mux, sel=0 routes a, sel=1 routes b.
module mux2x1_data #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/arb2_mux_ctrl.sv
// arb2_mux_ctrl: two-requester round-robin arbiter with a beat-limited hold, driving a shared 2:1 data mux.
module arb2_mux_ctrl
  import arb2_mux_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            last_q;
  logic            me, my_req, oth_req, beat, at_max;
  state_e          oth_state;
  assign gnt0      = state_q == OWN0;
  assign gnt1      = state_q == OWN1;
  assign sel       = gnt1;
  assign y_valid   = (gnt0 & req0) | (gnt1 & req1);
  assign beat      = y_valid & y_ready;
  assign me        = gnt1;
  assign my_req    = me ? req1 : req0;
  assign oth_req   = me ? req0 : req1;
  assign oth_state = me ? OWN0 : OWN1;
  assign at_max    = (int'(cnt_q) + 1) == MAX_HOLD;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
    end else if (state_q == IDLE) begin
      if (req0 && req1) state_q <= last_q ? OWN0 : OWN1;
      else if (req0) state_q <= OWN0;
      else if (req1) state_q <= OWN1;
    end else if (gnt0 || gnt1) begin
      if (!my_req || (beat && at_max && oth_req)) begin
        state_q <= oth_req ? oth_state : IDLE;
        last_q  <= me;
        cnt_q   <= '0;
      end else if (beat) begin
        cnt_q <= at_max ? '0 : cnt_q + 1'b1;
      end
    end else begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end
  end
  mux2x1_data #(.WIDTH(WIDTH)) u_mux (.a(a), .b(b), .sel(sel), .y(y));
endmodule
